// File: rtl/lb_arb2.sv
// Two-master local-bus arbiter/sequencer feeding a single slave port, with read timeout.
// Define LB_ARB2_FIXED_PRIO_EN for fixed priority (master 0 wins ties); default is round-robin.
module lb_arb2 #(
  parameter int unsigned TO_CYC  = 255,
  parameter int unsigned TO_BITS = 8,
  parameter logic [31:0] RD_FILL = 32'hDEADBEEF
) (
  input  logic        clk_lb,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_d,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rd_d,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_d,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rd_d,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TO_CYC - 1);

  state_t             state_q;
  logic               gnt_q;
  logic               we_q;
  logic [TO_BITS-1:0] to_cnt_q;
  logic               lb_wr_q, lb_rd_q, busy_q;
  logic [31:0]        lb_addr_q, lb_wr_d_q;
  logic               m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;
  logic [31:0]        m0_rd_d_q, m1_rd_d_q;

  logic               gnt_d;
  logic               gnt_we;
  logic [31:0]        gnt_addr, gnt_wr_d;

`ifdef LB_ARB2_FIXED_PRIO_EN
  always_comb begin
    gnt_d = ~m0_req;
  end
`else
  logic last_grant_q;

  // On a tie, serve whichever master was not granted last.
  always_comb begin
    gnt_d = m1_req;
    if (m0_req && m1_req) gnt_d = ~last_grant_q;
  end
`endif

  always_comb begin
    gnt_we   = gnt_d ? m1_we   : m0_we;
    gnt_addr = gnt_d ? m1_addr : m0_addr;
    gnt_wr_d = gnt_d ? m1_wr_d : m0_wr_d;
  end

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      to_cnt_q  <= '0;
      lb_wr_q   <= 1'b0;
      lb_rd_q   <= 1'b0;
      busy_q    <= 1'b0;
      lb_addr_q <= '0;
      lb_wr_d_q <= '0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      m0_err_q  <= 1'b0;
      m1_err_q  <= 1'b0;
      m0_rd_d_q <= '0;
      m1_rd_d_q <= '0;
`ifndef LB_ARB2_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      lb_wr_q  <= 1'b0;
      lb_rd_q  <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt_q     <= gnt_d;
            we_q      <= gnt_we;
            lb_addr_q <= gnt_addr;
            lb_wr_d_q <= gnt_wr_d;
            lb_wr_q   <= gnt_we;
            lb_rd_q   <= ~gnt_we;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
`ifndef LB_ARB2_FIXED_PRIO_EN
            last_grant_q <= gnt_d;
`endif
          end
        end
        ISSUE: begin
          if (we_q) begin
            m0_ack_q <= ~gnt_q;
            m1_ack_q <= gnt_q;
            state_q  <= DONE;
          end else begin
            to_cnt_q <= '0;
            state_q  <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // A ready arriving in the timeout cycle still delivers real data.
          if (lb_rd_rdy) begin
            if (gnt_q) m1_rd_d_q <= lb_rd_d;
            else       m0_rd_d_q <= lb_rd_d;
            m0_ack_q <= ~gnt_q;
            m1_ack_q <= gnt_q;
            state_q  <= DONE;
          end else if (to_cnt_q == TO_LAST) begin
            if (gnt_q) m1_rd_d_q <= RD_FILL;
            else       m0_rd_d_q <= RD_FILL;
            m0_ack_q <= ~gnt_q;
            m1_ack_q <= gnt_q;
            m0_err_q <= ~gnt_q;
            m1_err_q <= gnt_q;
            state_q  <= DONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_BITS'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lb_wr   = lb_wr_q;
  assign lb_rd   = lb_rd_q;
  assign lb_addr = lb_addr_q;
  assign lb_wr_d = lb_wr_d_q;
  assign busy    = busy_q;
  assign m0_ack  = m0_ack_q;
  assign m1_ack  = m1_ack_q;
  assign m0_err  = m0_err_q;
  assign m1_err  = m1_err_q;
  assign m0_rd_d = m0_rd_d_q;
  assign m1_rd_d = m1_rd_d_q;

endmodule

// File: tb/tb_lb_arb2.sv
// Directed bench for lb_arb2: expected transactions queued in grant order, checked at strobe and ack.
module tb_lb_arb2;
  localparam int unsigned TO_CYC = 4;
  localparam logic [31:0] FILL   = 32'hDEADBEEF;

  logic        clk_lb = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wr_d, m1_addr, m1_wr_d;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rd_d, m1_rd_d;
  logic        lb_wr, lb_rd, lb_rd_rdy, busy;
  logic [31:0] lb_addr, lb_wr_d, lb_rd_d;

  lb_arb2 #(.TO_CYC(TO_CYC), .TO_BITS(8), .RD_FILL(FILL)) dut (
    .clk_lb(clk_lb), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wr_d(m0_wr_d),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rd_d(m0_rd_d),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wr_d(m1_wr_d),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rd_d(m1_rd_d),
    .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
    .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy), .busy(busy)
  );

  always #5 clk_lb = ~clk_lb;

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] slv;
    logic [31:0] rd;
    bit          err;
    int          rdy_d;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rd[2];
  int          m_left[2];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // rdy_d: cycles after the lb_rd cycle that the slave answers; <1 means never.
  function automatic void push(bit m, bit we, logic [31:0] addr, logic [31:0] wd,
                               logic [31:0] slv, int rdy_d);
    exp_t e;
    bit   ok;
    ok = (rdy_d >= 1) && (rdy_d <= int'(TO_CYC));
    e.m = m; e.we = we; e.addr = addr; e.wd = wd; e.slv = slv; e.rdy_d = rdy_d;
    e.err = !we && !ok;
    if (!we) model_rd[m] = ok ? slv : FILL;
    e.rd  = model_rd[m];
    e.lat = we ? 1 : (ok ? rdy_d + 1 : int'(TO_CYC) + 1);
    sb.push_back(e);
  endfunction

  task automatic set_m(input bit m, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input int n);
    m_left[m] = n;
    if (m) begin m1_we = we; m1_addr = addr; m1_wr_d = wd; m1_req = 1'b1; end
    else   begin m0_we = we; m0_addr = addr; m0_wr_d = wd; m0_req = 1'b1; end
  endtask

  task automatic drop(input bit m);
    m_left[m]--;
    if (m_left[m] <= 0) begin
      if (m) m1_req = 1'b0;
      else   m0_req = 1'b0;
    end
  endtask

  task automatic run_one();
    exp_t e;
    bit   seen, done;
    int   c;
    seen = 0; done = 0; c = 0;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_empty: observed empty queue expected a transaction");
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk_lb);
      lb_rd_rdy = 1'b0;
      if (!seen) begin
        if (lb_wr || lb_rd) begin
          seen = 1;
          chk("strobe_kind", 32'({lb_wr, lb_rd}), e.we ? 32'd2 : 32'd1);
          chk("lb_addr", lb_addr, e.addr);
          if (e.we) chk("lb_wr_d", lb_wr_d, e.wd);
          chk("busy_active", 32'(busy), 32'd1);
        end
      end else begin
        c++;
        if (c == 1) chk("strobe_one_cycle", 32'({lb_wr, lb_rd}), 32'd0);
        if (m0_ack || m1_ack) begin
          done = 1;
          chk("ack_latency", 32'(c), 32'(e.lat));
          chk("ack_who", 32'({m1_ack, m0_ack}), e.m ? 32'd2 : 32'd1);
          chk("err", 32'(e.m ? m1_err : m0_err), 32'(e.err));
          chk("rd_d", e.m ? m1_rd_d : m0_rd_d, e.rd);
          drop(e.m);
        end
      end
      if (seen && !done && !e.we && c == e.rdy_d) begin
        lb_rd_rdy = 1'b1;
        lb_rd_d   = e.slv;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL txn_timeout: observed no ack expected ack from m%0d", e.m);
    end
  endtask

  initial begin
    reset_n = 1'b0; lb_rd_rdy = 1'b0; lb_rd_d = '0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wr_d = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wr_d = '0;
    model_rd[0] = '0; model_rd[1] = '0;
    m_left[0] = 0; m_left[1] = 0;
    repeat (2) @(negedge clk_lb);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({lb_wr, lb_rd}), 32'd0);
    chk("rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
    chk("rst_errs", 32'({m1_err, m0_err}), 32'd0);
    chk("rst_lb_addr", lb_addr, 32'd0);
    chk("rst_lb_wr_d", lb_wr_d, 32'd0);
    chk("rst_m0_rd_d", m0_rd_d, 32'd0);
    chk("rst_m1_rd_d", m1_rd_d, 32'd0);
    reset_n = 1'b1;
    @(negedge clk_lb);

    // m0 write
    push(1'b0, 1'b1, 32'h0, 32'h1, 32'h0, 0);
    set_m(1'b0, 1'b1, 32'h0, 32'h1, 1);
    run_one();
    @(negedge clk_lb);
    chk("idle_busy", 32'(busy), 32'd0);

    // m1 read, reply 3 cycles after lb_rd
    push(1'b1, 1'b0, 32'h4, 32'h0, 32'h12345678, 3);
    set_m(1'b1, 1'b0, 32'h4, 32'h0, 1);
    run_one();

    // both masters request continuously for four writes
    set_m(1'b0, 1'b1, 32'h100, 32'hA0A0_0000, 2);
    set_m(1'b1, 1'b1, 32'h200, 32'hB0B0_0000, 2);
`ifdef LB_ARB2_FIXED_PRIO_EN
    push(1'b0, 1'b1, 32'h100, 32'hA0A0_0000, 32'h0, 0);
    push(1'b0, 1'b1, 32'h100, 32'hA0A0_0000, 32'h0, 0);
    push(1'b1, 1'b1, 32'h200, 32'hB0B0_0000, 32'h0, 0);
    push(1'b1, 1'b1, 32'h200, 32'hB0B0_0000, 32'h0, 0);
`else
    push(1'b0, 1'b1, 32'h100, 32'hA0A0_0000, 32'h0, 0);
    push(1'b1, 1'b1, 32'h200, 32'hB0B0_0000, 32'h0, 0);
    push(1'b0, 1'b1, 32'h100, 32'hA0A0_0000, 32'h0, 0);
    push(1'b1, 1'b1, 32'h200, 32'hB0B0_0000, 32'h0, 0);
`endif
    repeat (4) run_one();

    // m0 read, slave silent -> timeout; then a late ready must be ignored
    push(1'b0, 1'b0, 32'h8, 32'h0, 32'h0, -1);
    set_m(1'b0, 1'b0, 32'h8, 32'h0, 1);
    run_one();
    @(negedge clk_lb);
    @(negedge clk_lb);
    lb_rd_rdy = 1'b1;
    lb_rd_d   = 32'h55AA55AA;
    @(negedge clk_lb);
    lb_rd_rdy = 1'b0;
    chk("late_rdy_acks", 32'({m1_ack, m0_ack}), 32'd0);
    chk("late_rdy_busy", 32'(busy), 32'd0);
    chk("late_rdy_m0_rd_d", m0_rd_d, FILL);
    @(negedge clk_lb);
    chk("late_rdy_acks2", 32'({m1_ack, m0_ack}), 32'd0);
    chk("late_rdy_m0_rd_d2", m0_rd_d, FILL);

    // ready in the very cycle the counter reaches TO_CYC-1
    push(1'b0, 1'b0, 32'hC, 32'h0, 32'h0BAD_F00D, int'(TO_CYC));
    set_m(1'b0, 1'b0, 32'hC, 32'h0, 1);
    run_one();

    // asynchronous reset during WAIT_RD
    set_m(1'b1, 1'b0, 32'h40, 32'h0, 1);
    for (int k = 0; k < 10 && !lb_rd; k++) @(negedge clk_lb);
    chk("pre_rst_lb_rd", 32'(lb_rd), 32'd1);
    @(negedge clk_lb);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_lb_rd", 32'(lb_rd), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
    chk("async_rst_m0_rd_d", m0_rd_d, 32'd0);
    m1_req = 1'b0;
    @(negedge clk_lb);
    reset_n = 1'b1;
    model_rd[0] = '0; model_rd[1] = '0;
    sb.delete();
    @(negedge clk_lb);
    chk("post_rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
    push(1'b1, 1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, 1);
    set_m(1'b1, 1'b0, 32'h44, 32'h0, 1);
    run_one();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed simulation still running expected completion");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/lb_arb2.md
Name: lb_arb2

Overview:
- Two-master arbiter and sequencer for the 32-bit local bus that feeds the SUMP2 control/data register pair.
- Master 0 is the host bridge (UART/SPI to local bus). Master 1 is an on-chip autonomous agent, for example a self-arming capture script.
- The block serialises both masters onto one slave port, one transaction at a time.
- It generates the single-cycle lb_wr/lb_rd strobes, waits for lb_rd_rdy on reads, and applies a read timeout so a lost ready cannot hang the bus.

Parameters:
- TO_CYC, 255: maximum WAIT_RD cycles before a read is aborted; must be at least 1.
- TO_BITS, 8: timeout counter width; TO_CYC must be < 2**TO_BITS.
- RD_FILL, 32'hDEADBEEF: data returned to the master on a timed-out read.

Ports:
- clk_lb  in  1  local bus clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1 each  transaction request; held high until ack
- m0_we, m1_we  in  1 each  1 = write, 0 = read; stable while req high
- m0_addr, m1_addr  in  32 each  address; stable while req high
- m0_wr_d, m1_wr_d  in  32 each  write data; stable while req high
- m0_ack, m1_ack  out  1 each  one-cycle completion pulse
- m0_err, m1_err  out  1 each  valid with ack; 1 = read timed out
- m0_rd_d, m1_rd_d  out  32 each  read data; valid with ack, held until the next ack to that master
- lb_wr, lb_rd  out  1 each  one-cycle strobes to the slave
- lb_addr, lb_wr_d  out  32 each  slave address and write data; held for the whole transaction
- lb_rd_d  in  32  slave read data
- lb_rd_rdy  in  1  slave read-data valid pulse
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; timeout counter 0.
  - last_grant = 1, so master 0 wins the first tie.
  - Reset is asynchronous and may hit in any state. It aborts the transaction in flight with no ack issued, and all strobes drop immediately.
- FSM states: IDLE -> ISSUE -> (WAIT_RD) -> DONE -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting: round-robin; grant the master that is not last_grant.
  - On grant: register gnt, lb_addr and lb_wr_d from the granted master, update last_grant, go to ISSUE.
- ISSUE:
  - Drive exactly one cycle of lb_wr = we or lb_rd = ~we.
  - Write: go to DONE.
  - Read: clear the timeout counter and go to WAIT_RD.
- WAIT_RD:
  - lb_rd_rdy = 1: capture lb_rd_d into the granted master's rd_d, err = 0, go to DONE.
  - lb_rd_rdy = 0: increment the counter. When counter == TO_CYC - 1, load RD_FILL into rd_d, set err = 1, go to DONE.
  - lb_rd_rdy arriving in the timeout cycle wins: real data, err = 0.
- DONE:
  - Assert the granted master's ack for one cycle; the other master's ack stays 0.
  - err is valid with ack. Go to IDLE.
- Requester rule: deassert req on the edge where ack = 1 is sampled. The arbiter re-samples req in IDLE on the following cycle.
- Latency:
  - Write: grant edge T0, lb_wr at T1, ack at T2, i.e. 3 cycles from req seen in IDLE.
  - Read: lb_rd at T1, ack one cycle after lb_rd_rdy.
- lb_rd_rdy seen in IDLE, ISSUE or DONE (for example a late reply after a timeout) is ignored and never forwarded.
- lb_addr and lb_wr_d hold their last values in IDLE; they are not cleared.
- A master asserting req while the other is being served waits; no request is ever dropped.

Optional Feature:
- Macro: LB_ARB2_FIXED_PRIO_EN.
- Defined: fixed priority, master 0 always wins a tie. last_grant is not implemented.
- Undefined: round-robin as described under Behaviour.

Test Plan:
- Reset, then m0 write addr 0x0, data 0x00000001 -> lb_wr high exactly at T1 with lb_addr = 0x0, lb_wr_d = 0x1; m0_ack at T2; m1_ack stays 0.
- m1 read addr 0x4, slave returns lb_rd_rdy 3 cycles after lb_rd with lb_rd_d = 0x12345678 -> m1_ack one cycle later, m1_rd_d = 0x12345678, m1_err = 0.
- m0 and m1 request simultaneously and continuously for 4 transactions -> grant order m0, m1, m0, m1. With LB_ARB2_FIXED_PRIO_EN defined, m1 is served only after m0 drops req.
- m0 read, slave never replies, TO_CYC = 4 -> m0_ack with m0_err = 1 and m0_rd_d = 0xDEADBEEF. A late lb_rd_rdy arriving 2 cycles after that ack is ignored: no ack, rd_d unchanged.
- lb_rd_rdy asserted in the same cycle the counter reaches TO_CYC - 1 -> real data returned, err = 0.
- reset_n pulsed low during WAIT_RD -> lb_rd, busy and both acks are 0 immediately. After release, a new m1 request completes normally.
